// File: rtl/bus_arbiter_pkg.sv
// Shared types and client indices for the main system bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        OWNED   = 2'b10,
        RELEASE = 2'b11
    } arb_state_t;

    localparam int CLIENT_IFETCH = 0;
    localparam int CLIENT_LOAD   = 1;
    localparam int CLIENT_STORE  = 2;
    localparam int CLIENT_WB     = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first set request bit at or above rr_ptr,
// wrapping past NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ     = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NREQ-1:0]     req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [ID_WIDTH-1:0] winner,
    output logic                any_req
);

    function automatic logic [ID_WIDTH-1:0] wrap(
        input logic [ID_WIDTH-1:0] ptr,
        input int                  k
    );
        int s;
        s = int'(ptr) + k;
        if (s >= NREQ) s = s - NREQ;
        return ID_WIDTH'(s);
    endfunction

    assign any_req = |req;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap(rr_ptr, k)]) winner = wrap(rr_ptr, k);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Main system bus arbiter: round-robin grant, held until the owner's
// transaction ends, then one turnaround cycle before re-arbitration.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int ID_WIDTH      = 2,
    parameter int GRANT_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     abtr_reqcyc,
    input  logic [NREQ-1:0]     bus_busy,
    output logic [NREQ-1:0]     abtr_grant,
    output logic                owner_valid,
    output logic [ID_WIDTH-1:0] owner_id,
    output logic                bus_idle,
    output logic                timeout_evt,
    output logic                protocol_err
);

    arb_state_t          state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] owner_q;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH-1:0] ptr_next;
    logic [7:0]          timer;
    logic [NREQ-1:0]     owner_mask;
    logic                any_req;
    logic                owner_busy;
    logic                no_busy;
    logic                busy_err;
    logic                timer_exp;

    rr_pick #(
        .NREQ    (NREQ),
        .ID_WIDTH(ID_WIDTH)
    ) u_pick (
        .req    (abtr_reqcyc),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .any_req(any_req)
    );

    // owner_q keeps the last owner through RELEASE for the busy check.
    assign owner_mask = NREQ'(1) << owner_q;
    assign owner_busy = |(bus_busy & owner_mask);
    assign no_busy    = (bus_busy == '0);
    assign busy_err   = (state == IDLE) ? !no_busy
                                        : |(bus_busy & ~owner_mask);
    assign timer_exp  = (timer == 8'(GRANT_TIMEOUT - 1));
    assign ptr_next   = (owner_q == ID_WIDTH'(NREQ - 1)) ? '0
                                                         : owner_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner_q      <= '0;
            timer        <= '0;
            abtr_grant   <= '0;
            owner_valid  <= 1'b0;
            owner_id     <= '0;
            bus_idle     <= 1'b1;
            timeout_evt  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            if (busy_err) protocol_err <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= GRANT;
                        owner_q     <= winner;
                        owner_id    <= winner;
                        owner_valid <= 1'b1;
                        abtr_grant  <= NREQ'(1) << winner;
                        timer       <= '0;
                        bus_idle    <= 1'b0;
                    end else begin
                        bus_idle <= no_busy;
                    end
                end
                GRANT: begin
                    timer <= timer + 1'b1;
                    if (owner_busy) begin
                        state <= OWNED;
                    end else if (timer_exp) begin
                        state       <= RELEASE;
                        rr_ptr      <= ptr_next;
                        abtr_grant  <= '0;
                        owner_valid <= 1'b0;
                        owner_id    <= '0;
                        timeout_evt <= 1'b1;
                        bus_idle    <= no_busy;
                    end
                end
                OWNED: begin
                    if (!owner_busy) begin
                        state       <= RELEASE;
                        rr_ptr      <= ptr_next;
                        abtr_grant  <= '0;
                        owner_valid <= 1'b0;
                        owner_id    <= '0;
                        bus_idle    <= no_busy;
                    end
                end
                RELEASE: begin
                    state    <= IDLE;
                    bus_idle <= no_busy;
                end
            endcase
        end
    end

endmodule
